alu_overflow_monitor: RTL and testbench

//  Parametrised successor of the 4-bit overflow detector: registered add/sub/logic

---
 rtl/alu_overflow_monitor.sv | 116 +++++++++++
 tb/tb_alu_overflow_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_overflow_monitor.sv
// Registered add/sub/logic stage with valid/ready handshake, signed overflow
// detection, and sticky/saturating overflow statistics. Optional: OVF_SATURATE_EN.
module alu_overflow_monitor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       opCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             CarryOUT,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  input  logic             clr_stat,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  logic             accept;
  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] y_c;
  logic             carry_c;
  logic             ovf_c;

  // No skid buffer: a new operand is taken only when the output slot frees up.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Subtraction reuses the adder as A + ~B + 1.
  assign is_sub  = (opCode == OP_SUB);
  assign b_op    = is_sub ? ~B : B;
  assign sum_ext = (WIDTH+1)'(A) + (WIDTH+1)'(b_op) + (WIDTH+1)'(is_sub);

  // Result and flag selection for the current operands.
  always_comb begin
    y_c     = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (opCode)
      OP_AND: y_c = A & B;
      OP_OR:  y_c = A | B;
      OP_ADD: begin
        carry_c = sum_ext[WIDTH];
        ovf_c   = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
        y_c     = sum_ext[WIDTH-1:0];
      end
      default: begin
        carry_c = sum_ext[WIDTH];
        ovf_c   = (A[MSB] != B[MSB]) && (sum_ext[MSB] != A[MSB]);
        y_c     = sum_ext[WIDTH-1:0];
      end
    endcase
`ifdef OVF_SATURATE_EN
    // Clamp toward the sign of A: positive overflow -> max, negative -> min.
    if (ovf_c) begin
      y_c = A[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Output register: load on accept, hold under backpressure, drop on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Y         <= '0;
      CarryOUT  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      Y         <= y_c;
      CarryOUT  <= carry_c;
      overflow  <= ovf_c;
      zero      <= (y_c == '0);
      negative  <= y_c[MSB];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Statistics: a same-cycle overflow event takes precedence over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (accept && ovf_c) begin
      ovf_sticky <= 1'b1;
      if (clr_stat) begin
        ovf_count <= CNT_W'(1);
      end else if (!(&ovf_count)) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end else if (clr_stat) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_alu_overflow_monitor.sv
// Directed self-checking bench for alu_overflow_monitor (WIDTH=4, CNT_W=2).
module tb_alu_overflow_monitor;

`ifdef OVF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] opCode;
  logic [3:0] A;
  logic [3:0] B;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] Y;
  logic       CarryOUT;
  logic       overflow;
  logic       zero;
  logic       negative;
  logic       clr_stat;
  logic       ovf_sticky;
  logic [1:0] ovf_count;

  int checks = 0;
  int failures = 0;

  alu_overflow_monitor #(.WIDTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opCode(opCode), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .CarryOUT(CarryOUT), .overflow(overflow), .zero(zero),
    .negative(negative), .clr_stat(clr_stat), .ovf_sticky(ovf_sticky),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for one cycle, then deassert in_valid.
  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1; opCode = op; A = a; B = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Compare all result-side outputs against expected {valid,Y,C,V,Z,N}.
  task automatic test_result(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = {out_valid, Y, CarryOUT, overflow, zero, negative};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got {v,Y,C,V,Z,N}=%b required=%b", name, got, exp);
    end
  endtask

  task automatic test_stats(input string name, input logic exp_s, input logic [1:0] exp_c);
    checks++;
    if ({ovf_sticky, ovf_count} !== {exp_s, exp_c}) begin
      failures++;
      $display("FAIL %s got sticky=%b count=%0d required sticky=%b count=%0d",
               name, ovf_sticky, ovf_count, exp_s, exp_c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_stat = 1'b0;
    opCode = 2'b00; A = 4'h0; B = 4'h0;
    tick(); tick();
    rst = 1'b0;
    test_result("reset_outputs", 9'b0_0000_0000);
    test_stats("reset_stats", 1'b0, 2'd0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_arith();
    out_ready = 1'b1;
    issue(2'b10, 4'h7, 4'h1);
    test_result("add_7_1", SAT ? {1'b1, 4'h7, 4'b0100} : {1'b1, 4'h8, 4'b0101});
    issue(2'b10, 4'hF, 4'h1);
    test_result("add_F_1", {1'b1, 4'h0, 4'b1010});
    issue(2'b11, 4'h8, 4'h1);
    test_result("sub_8_1", SAT ? {1'b1, 4'h8, 4'b1101} : {1'b1, 4'h7, 4'b1100});
    issue(2'b11, 4'h3, 4'h5);
    test_result("sub_3_5", {1'b1, 4'hE, 4'b0001});
    issue(2'b11, 4'h5, 4'h5);
    test_result("sub_5_5", {1'b1, 4'h0, 4'b1010});
    issue(2'b10, 4'h8, 4'h8);
    test_result("add_8_8", SAT ? {1'b1, 4'h8, 4'b1101} : {1'b1, 4'h0, 4'b1110});
    test_stats("stats_after_arith", 1'b1, 2'd3);
  endtask

  task automatic test_logic();
    out_ready = 1'b1;
    issue(2'b00, 4'hC, 4'hA);
    test_result("and_C_A", {1'b1, 4'h8, 4'b0001});
    issue(2'b01, 4'h5, 4'hA);
    test_result("or_5_A", {1'b1, 4'hF, 4'b0001});
    issue(2'b00, 4'h5, 4'hA);
    test_result("and_5_A", {1'b1, 4'h0, 4'b0010});
    tick();
    test_result("idle_drop_valid", {1'b0, 4'h0, 4'b0010});
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(2'b10, 4'h2, 4'h3);
    test_result("bp_accept", {1'b1, 4'h5, 4'b0000});
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready_%0d got=%b required=0", i, in_ready);
      end
      in_valid = 1'b1; opCode = 2'b10; A = 4'h7; B = 4'h7;
      tick();
      test_result("bp_hold", {1'b1, 4'h5, 4'b0000});
    end
    in_valid = 1'b0;
    test_stats("bp_no_stat_when_blocked", 1'b0, 2'd0);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_in_ready got=%b required=1", in_ready);
    end
    tick();
    test_result("bp_transfer", {1'b0, 4'h5, 4'b0000});
  endtask

  task automatic clear_stats(input string name);
    in_valid = 1'b0; clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    test_stats(name, 1'b0, 2'd0);
  endtask

  task automatic test_saturating_count();
    logic [1:0] exp_c;
    out_ready = 1'b1;
    in_valid = 1'b1; opCode = 2'b10; A = 4'h7; B = 4'h1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_c = (i >= 3) ? 2'd3 : 2'(i);
      test_stats("cnt_saturate", 1'b1, exp_c);
    end
    in_valid = 1'b0;
    clear_stats("clr_after_saturate");
  endtask

  task automatic test_clr_with_event();
    out_ready = 1'b1;
    issue(2'b10, 4'h7, 4'h1);
    issue(2'b10, 4'h7, 4'h1);
    test_stats("pre_clr_event", 1'b1, 2'd2);
    clr_stat = 1'b1;
    issue(2'b10, 4'h7, 4'h1);
    clr_stat = 1'b0;
    test_stats("clr_same_cycle_event", 1'b1, 2'd1);
    clr_stat = 1'b1;
    issue(2'b10, 4'h1, 4'h1);
    clr_stat = 1'b0;
    test_stats("clr_with_non_ovf_accept", 1'b0, 2'd0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1;
    opCode = 2'b10; A = 4'h1; B = 4'h2; tick();
    test_result("b2b_0", {1'b1, 4'h3, 4'b0000});
    opCode = 2'b11; A = 4'h1; B = 4'h2; tick();
    test_result("b2b_1", {1'b1, 4'hF, 4'b0001});
    opCode = 2'b01; A = 4'h0; B = 4'h0; tick();
    test_result("b2b_2", {1'b1, 4'h0, 4'b0010});
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    issue(2'b10, 4'h7, 4'h1);
    test_stats("mid_pre_reset", 1'b1, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_result("mid_reset_outputs", 9'b0_0000_0000);
    test_stats("mid_reset_stats", 1'b0, 2'd0);
  endtask

  initial begin
    test_reset();
    test_arith();
    clear_stats("clr_after_arith");
    test_logic();
    test_backpressure();
    test_saturating_count();
    test_clr_with_event();
    test_back_to_back();
    clear_stats("clr_before_mid_reset");
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
